// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Groups every signal between the mini-SRC control unit and its datapath.
//
//   Datapath -> sequencer:
//     ir[31:0]   instruction register contents, opcode in ir[31:27]
//     con_ff     branch condition flip-flop
//     mem_ready  memory finished the current read or write
//     step       single-step advance pulse (only used with STEP_MODE_EN)
//   Sequencer -> datapath:
//     PCout, Zlowout, MDRout, Cout                bus drivers
//     PCin, IRin, MARin, MDRin, Yin, Zin, CONin   register loads
//     IncPC, Read, Write, Mdatain                 PC increment / memory strobes
//     Gra, Grb, Grc, Rin, Rout, BAout             select-and-encode controls
//     alu_op[ALU_OP_W-1:0]                        0 add, 1 sub, 2 and, 3 or
//     run                                         high unless halted
//
//   modport master: the sequencer side.  modport slave: the datapath side.
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int ALU_OP_W = 4
);
  logic [31:0]         ir;
  logic                con_ff;
  logic                mem_ready;
  logic                step;

  logic                PCout, Zlowout, MDRout, Cout;
  logic                PCin, IRin, MARin, MDRin, Yin, Zin, CONin;
  logic                IncPC, Read, Write, Mdatain;
  logic                Gra, Grb, Grc, Rin, Rout, BAout;
  logic [ALU_OP_W-1:0] alu_op;
  logic                run;

  modport master (
    input  ir, con_ff, mem_ready, step,
    output PCout, Zlowout, MDRout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, CONin,
    output IncPC, Read, Write, Mdatain,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output alu_op, run
  );

  modport slave (
    output ir, con_ff, mem_ready, step,
    input  PCout, Zlowout, MDRout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, CONin,
    input  IncPC, Read, Write, Mdatain,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  alu_op, run
  );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control unit for the mini-SRC datapath.  Fetches an
//   instruction (T0..T2), then steps through T3..T7 producing every bus,
//   register-load and memory strobe.  Stalls in T1, ld T6 and st T7 until
//   mem_ready is high.  A halt instruction parks the FSM in HALT until reset.
//
//   Ports:
//     clock  rising-edge system clock
//     reset  synchronous, active-high; forces all strobes and alu_op to 0
//            while high and returns the FSM to T0
//     bus    instr_sequencer_if.master (ir/con_ff/mem_ready/step in,
//            all control strobes, alu_op and run out)
//
//   Build option:
//     STEP_MODE_EN  when defined, every instruction ends in STEP_WAIT and
//                   waits for a step pulse before fetching the next one.
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ALU_OP_W = 4
) (
  input logic               clock,
  input logic               reset,
  instr_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7,
`ifdef STEP_MODE_EN
    HALT,
    STEP_WAIT
`else
    HALT
`endif
  } state_t;

`ifdef STEP_MODE_EN
  localparam state_t DoneState = STEP_WAIT;
`else
  localparam state_t DoneState = T0;
`endif

  localparam logic [4:0] OpLd   = 5'b00000, OpLdi  = 5'b00001, OpSt  = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011, OpSub  = 5'b00100, OpAnd = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110, OpAddi = 5'b01100, OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110, OpBr   = 5'b10010, OpJr  = 5'b10011;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef struct packed {
    logic PCout, Zlowout, MDRout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin;
    logic IncPC, Read, Write, Mdatain;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
  } strobe_t;

  state_t              state_q, state_d;
  strobe_t             strobes, strobesOut;
  logic [ALU_OP_W-1:0] aluOp, aluCode;
  logic [4:0]          opcode;
  logic                isRType, isImm, isAddr, isLd, isSt, isBr, isJr, isHalt;
  logic                isKnown;
  logic                unusedBits;

  assign opcode = bus.ir[31:27];

`ifdef STEP_MODE_EN
  assign unusedBits = ^bus.ir[26:0];
`else
  assign unusedBits = ^{bus.ir[26:0], bus.step};
`endif

  // Opcode classes; ld, ldi and st share the effective-address steps T3..T5.
  always_comb begin
    isRType = (opcode == OpAdd) || (opcode == OpSub) ||
              (opcode == OpAnd) || (opcode == OpOr);
    isImm   = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpOri);
    isLd    = (opcode == OpLd);
    isSt    = (opcode == OpSt);
    isAddr  = isLd || isSt || (opcode == OpLdi);
    isBr    = (opcode == OpBr);
    isJr    = (opcode == OpJr);
    isHalt  = (opcode == OpHalt);
    isKnown = isRType || isImm || isAddr || isBr || isJr || isHalt;
  end

  // ALU function selected by the arithmetic/logic opcodes.
  always_comb begin
    aluCode = '0;
    case (opcode)
      OpSub:          aluCode = ALU_OP_W'(1);
      OpAnd, OpAndi:  aluCode = ALU_OP_W'(2);
      OpOr,  OpOri:   aluCode = ALU_OP_W'(3);
      default:        aluCode = '0;
    endcase
  end

  // State register; reset abandons whatever instruction is in flight.
  always_ff @(posedge clock) begin
    if (reset) state_q <= T0;
    else       state_q <= state_d;
  end

  // Next-state and strobe decode.  Memory stalls simply hold the state, so
  // the strobes of that state (e.g. Write in st T7) repeat every stall cycle.
  always_comb begin
    state_d = state_q;
    strobes = '0;
    aluOp   = '0;
    case (state_q)
      T0: begin
        strobes.PCout = 1'b1; strobes.MARin = 1'b1;
        strobes.IncPC = 1'b1; strobes.Zin   = 1'b1;
        state_d = T1;
      end
      T1: begin
        strobes.Zlowout = 1'b1; strobes.Read  = 1'b1;
        strobes.Mdatain = 1'b1; strobes.MDRin = 1'b1;
        // PC is loaded only once, on the cycle the fetch completes.
        strobes.PCin = bus.mem_ready;
        if (bus.mem_ready) state_d = T2;
      end
      T2: begin
        strobes.MDRout = 1'b1; strobes.IRin = 1'b1;
        state_d = isKnown ? T3 : DoneState;
      end
      T3: begin
        state_d = T4;
        if (isRType || isImm) begin
          strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.Yin = 1'b1;
        end else if (isAddr) begin
          strobes.Grb = 1'b1; strobes.BAout = 1'b1; strobes.Yin = 1'b1;
        end else if (isBr) begin
          strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.CONin = 1'b1;
        end else if (isJr) begin
          strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.PCin = 1'b1;
          state_d = DoneState;
        end else if (isHalt) begin
          state_d = HALT;
        end else begin
          state_d = DoneState;
        end
      end
      T4: begin
        state_d = T5;
        if (isRType) begin
          strobes.Grc = 1'b1; strobes.Rout = 1'b1; strobes.Zin = 1'b1;
          aluOp = aluCode;
        end else if (isImm) begin
          strobes.Cout = 1'b1; strobes.Zin = 1'b1;
          aluOp = aluCode;
        end else if (isAddr) begin
          strobes.Cout = 1'b1; strobes.Zin = 1'b1;
        end else if (isBr) begin
          strobes.PCout = 1'b1; strobes.Yin = 1'b1;
        end else begin
          state_d = DoneState;
        end
      end
      T5: begin
        state_d = DoneState;
        if (isLd || isSt) begin
          strobes.Zlowout = 1'b1; strobes.MARin = 1'b1;
          state_d = T6;
        end else if (isRType || isImm || isAddr) begin
          strobes.Zlowout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
        end else if (isBr) begin
          strobes.Cout = 1'b1; strobes.Zin = 1'b1;
          state_d = T6;
        end
      end
      T6: begin
        state_d = DoneState;
        if (isLd) begin
          strobes.Read = 1'b1; strobes.Mdatain = 1'b1; strobes.MDRin = 1'b1;
          state_d = bus.mem_ready ? T7 : T6;
        end else if (isSt) begin
          strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.MDRin = 1'b1;
          state_d = T7;
        end else if (isBr) begin
          strobes.Zlowout = 1'b1;
          strobes.PCin    = bus.con_ff;
        end
      end
      T7: begin
        state_d = DoneState;
        if (isLd) begin
          strobes.MDRout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
        end else if (isSt) begin
          strobes.Write = 1'b1;
          state_d = bus.mem_ready ? DoneState : T7;
        end
      end
      HALT: state_d = HALT;
`ifdef STEP_MODE_EN
      STEP_WAIT: if (bus.step) state_d = T0;
`endif
      default: state_d = T0;
    endcase
  end

  // Reset overrides every strobe so no partial write leaks out.
  assign strobesOut = reset ? '0 : strobes;

  assign bus.PCout   = strobesOut.PCout;
  assign bus.Zlowout = strobesOut.Zlowout;
  assign bus.MDRout  = strobesOut.MDRout;
  assign bus.Cout    = strobesOut.Cout;
  assign bus.PCin    = strobesOut.PCin;
  assign bus.IRin    = strobesOut.IRin;
  assign bus.MARin   = strobesOut.MARin;
  assign bus.MDRin   = strobesOut.MDRin;
  assign bus.Yin     = strobesOut.Yin;
  assign bus.Zin     = strobesOut.Zin;
  assign bus.CONin   = strobesOut.CONin;
  assign bus.IncPC   = strobesOut.IncPC;
  assign bus.Read    = strobesOut.Read;
  assign bus.Write   = strobesOut.Write;
  assign bus.Mdatain = strobesOut.Mdatain;
  assign bus.Gra     = strobesOut.Gra;
  assign bus.Grb     = strobesOut.Grb;
  assign bus.Grc     = strobesOut.Grc;
  assign bus.Rin     = strobesOut.Rin;
  assign bus.Rout    = strobesOut.Rout;
  assign bus.BAout   = strobesOut.BAout;
  assign bus.alu_op  = reset ? '0 : aluOp;
  assign bus.run     = (state_q != HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Table-driven bench for instr_sequencer.  Each record is one clock cycle:
//   the inputs to drive and the strobe vector / alu_op the control unit must
//   produce during that cycle.  Sequences cover fetch stalls, R-type and
//   immediate ALU ops, ld/st with memory stalls, br taken/not taken, jr,
//   nop/undefined opcodes, halt and reset in the middle of an instruction.
//   When built with STEP_MODE_EN the single-step sequence is used instead.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  // Strobe vector bit positions.
  localparam logic [21:0] M_PCOUT   = 22'd1 << 21;
  localparam logic [21:0] M_ZLOWOUT = 22'd1 << 20;
  localparam logic [21:0] M_MDROUT  = 22'd1 << 19;
  localparam logic [21:0] M_COUT    = 22'd1 << 18;
  localparam logic [21:0] M_PCIN    = 22'd1 << 17;
  localparam logic [21:0] M_IRIN    = 22'd1 << 16;
  localparam logic [21:0] M_MARIN   = 22'd1 << 15;
  localparam logic [21:0] M_MDRIN   = 22'd1 << 14;
  localparam logic [21:0] M_YIN     = 22'd1 << 13;
  localparam logic [21:0] M_ZIN     = 22'd1 << 12;
  localparam logic [21:0] M_CONIN   = 22'd1 << 11;
  localparam logic [21:0] M_INCPC   = 22'd1 << 10;
  localparam logic [21:0] M_READ    = 22'd1 << 9;
  localparam logic [21:0] M_WRITE   = 22'd1 << 8;
  localparam logic [21:0] M_MDATAIN = 22'd1 << 7;
  localparam logic [21:0] M_GRA     = 22'd1 << 6;
  localparam logic [21:0] M_GRB     = 22'd1 << 5;
  localparam logic [21:0] M_GRC     = 22'd1 << 4;
  localparam logic [21:0] M_RIN     = 22'd1 << 3;
  localparam logic [21:0] M_ROUT    = 22'd1 << 2;
  localparam logic [21:0] M_BAOUT   = 22'd1 << 1;
  localparam logic [21:0] M_RUN     = 22'd1;

  // Expected per-state strobe sets, written out from the instruction table.
  localparam logic [21:0] F_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [21:0] F_T1W = M_ZLOWOUT | M_READ | M_MDATAIN | M_MDRIN | M_RUN;
  localparam logic [21:0] F_T1  = F_T1W | M_PCIN;
  localparam logic [21:0] F_T2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [21:0] R_T3  = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [21:0] R_T4  = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [21:0] W_T5  = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [21:0] C_T4  = M_COUT | M_ZIN | M_RUN;
  localparam logic [21:0] A_T3  = M_GRB | M_BAOUT | M_YIN | M_RUN;
  localparam logic [21:0] A_T5  = M_ZLOWOUT | M_MARIN | M_RUN;
  localparam logic [21:0] LD_T6 = M_READ | M_MDATAIN | M_MDRIN | M_RUN;
  localparam logic [21:0] LD_T7 = M_MDROUT | M_GRA | M_RIN | M_RUN;
  localparam logic [21:0] ST_T6 = M_GRA | M_ROUT | M_MDRIN | M_RUN;
  localparam logic [21:0] ST_T7 = M_WRITE | M_RUN;
  localparam logic [21:0] BR_T3 = M_GRA | M_ROUT | M_CONIN | M_RUN;
  localparam logic [21:0] BR_T4 = M_PCOUT | M_YIN | M_RUN;
  localparam logic [21:0] BR_T6 = M_ZLOWOUT | M_RUN;
  localparam logic [21:0] JR_T3 = M_GRA | M_ROUT | M_PCIN | M_RUN;
  localparam logic [21:0] IDLE  = M_RUN;
  localparam logic [21:0] NONE  = 22'd0;

  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_SUB  = 32'h20000000;
  localparam logic [31:0] IR_ANDI = 32'h68000000;
  localparam logic [31:0] IR_ORI  = 32'h70000000;
  localparam logic [31:0] IR_LDI  = 32'h08000000;
  localparam logic [31:0] IR_LD   = 32'h00000000;
  localparam logic [31:0] IR_ST   = 32'h10000000;
  localparam logic [31:0] IR_BR   = 32'h90000000;
  localparam logic [31:0] IR_JR   = 32'h98000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_UND  = 32'hF8000000;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        conFf;
    logic        memReady;
    logic        step;
    logic        rst;
    logic [21:0] expStrobes;
    logic [3:0]  expAlu;
  } vec_t;

  logic clock;
  logic reset;
  vec_t vecs[$];
  int   checks;
  int   errors;

  instr_sequencer_if #(.ALU_OP_W(4)) bus ();

  instr_sequencer #(.ALU_OP_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic addRow(input string name, input logic [31:0] ir,
                        input logic conFf, input logic memReady,
                        input logic step, input logic rst,
                        input logic [21:0] expStrobes, input logic [3:0] expAlu);
    vec_t v;
    v.name = name; v.ir = ir; v.conFf = conFf; v.memReady = memReady;
    v.step = step; v.rst = rst; v.expStrobes = expStrobes; v.expAlu = expAlu;
    vecs.push_back(v);
  endtask

  // Fetch with an immediately ready memory.
  task automatic addFetch(input string name, input logic [31:0] ir);
    addRow({name, ".T0"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, F_T0, 4'd0);
    addRow({name, ".T1"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, F_T1, 4'd0);
    addRow({name, ".T2"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, F_T2, 4'd0);
  endtask

  task automatic addAlu(input string name, input logic [31:0] ir,
                        input logic [21:0] t4, input logic [3:0] alu);
    addFetch(name, ir);
    addRow({name, ".T3"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, R_T3, 4'd0);
    addRow({name, ".T4"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, t4,   alu);
    addRow({name, ".T5"}, ir, 1'b0, 1'b1, 1'b0, 1'b0, W_T5, 4'd0);
  endtask

  task automatic addBranch(input string name, input logic con);
    addFetch(name, IR_BR);
    // mem_ready held low here: it must have no effect outside T1/T6/T7 memory states.
    addRow({name, ".T3"}, IR_BR, con, 1'b0, 1'b0, 1'b0, BR_T3, 4'd0);
    addRow({name, ".T4"}, IR_BR, con, 1'b0, 1'b0, 1'b0, BR_T4, 4'd0);
    addRow({name, ".T5"}, IR_BR, con, 1'b0, 1'b0, 1'b0, C_T4,  4'd0);
    addRow({name, ".T6"}, IR_BR, con, 1'b0, 1'b0, 1'b0,
           con ? (BR_T6 | M_PCIN) : BR_T6, 4'd0);
  endtask

  // Build the cycle-by-cycle vector table.
  task automatic buildTable();
    addRow("reset", IR_ADD, 1'b0, 1'b1, 1'b0, 1'b1, IDLE, 4'd0);
`ifdef STEP_MODE_EN
    addFetch("nop1", IR_NOP);
    for (int i = 0; i < 3; i++)
      addRow("nop1.wait", IR_NOP, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, 4'd0);
    addRow("nop1.step", IR_NOP, 1'b0, 1'b1, 1'b1, 1'b0, IDLE, 4'd0);
    addFetch("nop2", IR_NOP);
    addRow("nop2.wait", IR_NOP, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, 4'd0);
    addRow("nop2.wait", IR_NOP, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, 4'd0);
`else
    addAlu("add",  IR_ADD,  R_T4, 4'd0);
    addAlu("sub",  IR_SUB,  R_T4, 4'd1);
    addAlu("andi", IR_ANDI, C_T4, 4'd2);
    addAlu("ori",  IR_ORI,  C_T4, 4'd3);

    // ldi shares the address-computation steps, then writes Ra.
    addFetch("ldi", IR_LDI);
    addRow("ldi.T3", IR_LDI, 1'b0, 1'b1, 1'b0, 1'b0, A_T3, 4'd0);
    addRow("ldi.T4", IR_LDI, 1'b0, 1'b1, 1'b0, 1'b0, C_T4, 4'd0);
    addRow("ldi.T5", IR_LDI, 1'b0, 1'b1, 1'b0, 1'b0, W_T5, 4'd0);

    // Fetch stall: three not-ready T1 cycles, PCin only on the exit cycle.
    addRow("stall.T0", IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0, F_T0, 4'd0);
    for (int i = 0; i < 3; i++)
      addRow("stall.T1w", IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0, F_T1W, 4'd0);
    addRow("stall.T1", IR_NOP, 1'b0, 1'b1, 1'b0, 1'b0, F_T1, 4'd0);
    addRow("stall.T2", IR_NOP, 1'b0, 1'b1, 1'b0, 1'b0, F_T2, 4'd0);

    addFetch("undef", IR_UND);

    addBranch("brNT", 1'b0);
    addBranch("brT",  1'b1);

    addFetch("jr", IR_JR);
    addRow("jr.T3", IR_JR, 1'b0, 1'b1, 1'b0, 1'b0, JR_T3, 4'd0);

    // st with two not-ready cycles in T7: Write held for three cycles.
    addFetch("st", IR_ST);
    addRow("st.T3", IR_ST, 1'b0, 1'b1, 1'b0, 1'b0, A_T3,  4'd0);
    addRow("st.T4", IR_ST, 1'b0, 1'b1, 1'b0, 1'b0, C_T4,  4'd0);
    addRow("st.T5", IR_ST, 1'b0, 1'b1, 1'b0, 1'b0, A_T5,  4'd0);
    addRow("st.T6", IR_ST, 1'b0, 1'b0, 1'b0, 1'b0, ST_T6, 4'd0);
    addRow("st.T7a", IR_ST, 1'b0, 1'b0, 1'b0, 1'b0, ST_T7, 4'd0);
    addRow("st.T7b", IR_ST, 1'b0, 1'b0, 1'b0, 1'b0, ST_T7, 4'd0);
    addRow("st.T7c", IR_ST, 1'b0, 1'b1, 1'b0, 1'b0, ST_T7, 4'd0);

    // ld with one not-ready cycle in T6.
    addFetch("ld", IR_LD);
    addRow("ld.T3", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, A_T3,  4'd0);
    addRow("ld.T4", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, C_T4,  4'd0);
    addRow("ld.T5", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, A_T5,  4'd0);
    addRow("ld.T6w", IR_LD, 1'b0, 1'b0, 1'b0, 1'b0, LD_T6, 4'd0);
    addRow("ld.T6", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, LD_T6, 4'd0);
    addRow("ld.T7", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, LD_T7, 4'd0);

    // Reset in ld T5: all strobes silenced, then a fresh fetch.
    addFetch("ldR", IR_LD);
    addRow("ldR.T3", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, A_T3, 4'd0);
    addRow("ldR.T4", IR_LD, 1'b0, 1'b1, 1'b0, 1'b0, C_T4, 4'd0);
    addRow("ldR.T5rst", IR_LD, 1'b0, 1'b1, 1'b0, 1'b1, IDLE, 4'd0);

    // halt: run drops after T3 and stays low until reset.
    addFetch("halt", IR_HALT);
    addRow("halt.T3", IR_HALT, 1'b0, 1'b1, 1'b0, 1'b0, IDLE, 4'd0);
    for (int i = 0; i < 20; i++)
      addRow("halt.H", IR_HALT, 1'b0, (i % 2) == 0, 1'b1, 1'b0, NONE, 4'd0);
    addRow("halt.rst", IR_HALT, 1'b0, 1'b1, 1'b0, 1'b1, NONE, 4'd0);
    addRow("halt.T0", IR_ADD, 1'b0, 1'b1, 1'b0, 1'b0, F_T0, 4'd0);
`endif
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    bus.ir        = v.ir;
    bus.con_ff    = v.conFf;
    bus.mem_ready = v.memReady;
    bus.step      = v.step;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [21:0] got;
    got = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.PCin, bus.IRin,
           bus.MARin, bus.MDRin, bus.Yin, bus.Zin, bus.CONin, bus.IncPC,
           bus.Read, bus.Write, bus.Mdatain, bus.Gra, bus.Grb, bus.Grc,
           bus.Rin, bus.Rout, bus.BAout, bus.run};
    checks++;
    if (got !== v.expStrobes) begin
      errors++;
      $display("[TB] FAIL row %0d %s strobes: got %06h expected %06h",
               idx, v.name, got, v.expStrobes);
    end
    checks++;
    if (bus.alu_op !== v.expAlu) begin
      errors++;
      $display("[TB] FAIL row %0d %s alu_op: got %0d expected %0d",
               idx, v.name, bus.alu_op, v.expAlu);
    end
  endtask

  // Main sequence: one reset edge to leave the unknown start state, then one
  // table row per cycle, driven just after the edge and checked mid-cycle.
  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.ir        = IR_ADD;
    bus.con_ff    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.step      = 1'b0;
    buildTable();
    @(posedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      applyStimulus(vecs[i]);
      #3;
      checkOutput(i, vecs[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
